// File: rtl/perf_uart_reporter_if.sv
// Report interface between the pipelined core's counters and the UART perf reporter.
// The core side (master) drives the trigger and counter snapshot inputs; the reporter (slave) drives the serial line and status.
interface perf_uart_reporter_if;
  logic        trigger;
  logic [31:0] total_cycles;
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
  logic [31:0] pc_in;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_count;

  modport master (
    output trigger, total_cycles, stall_cycles, flush_cycles, pc_in,
    input  uart_tx, busy, frame_done, drop_count
  );

  modport slave (
    input  trigger, total_cycles, stall_cycles, flush_cycles, pc_in,
    output uart_tx, busy, frame_done, drop_count
  );
endinterface

// File: rtl/perf_uart_reporter.sv
// Snapshots the core perf counters and pc on trigger and streams them as an 8N1 UART frame.
// Define PERF_UART_CHECKSUM_EN to append an XOR checksum byte (18-byte frame instead of 17).
module perf_uart_reporter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst_n,
  perf_uart_reporter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef PERF_UART_CHECKSUM_EN
  localparam logic [4:0]  LAST_BYTE = 5'd17;
`else
  localparam logic [4:0]  LAST_BYTE = 5'd16;
`endif

  state_t       state_q, state_d;
  logic [15:0]  baud_q, baud_d;
  logic [2:0]   bit_q, bit_d;
  logic [4:0]   byte_q, byte_d;
  logic         tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [7:0]   drop_q;
  logic [127:0] snap_q;

  logic         accept;
  logic         baud_end;
  logic [2:0]   bit_inc;
  logic [7:0]   cur_byte;

  assign accept   = bus.trigger && !busy_q;
  assign baud_end = (baud_q == BAUD_LAST);
  assign bit_inc  = bit_q + 3'd1;

`ifdef PERF_UART_CHECKSUM_EN
  logic [7:0] checksum;

  always_comb begin
    checksum = 8'h00;
    for (int k = 0; k < 16; k++) checksum = checksum ^ snap_q[k*8 +: 8];
  end
`endif

  // Byte 0 is sync; bytes 1..16 walk the snapshot MSB first.
  always_comb begin
    cur_byte = SYNC_BYTE;
    for (int k = 1; k <= 16; k++) begin
      if (byte_q == 5'(k)) cur_byte = snap_q[(16-k)*8 +: 8];
    end
`ifdef PERF_UART_CHECKSUM_EN
    if (byte_q == 5'd17) cur_byte = checksum;
`endif
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = 16'd0;
        bit_d  = 3'd0;
        byte_d = 5'd0;
        if (accept) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_inc;
            tx_d  = cur_byte[bit_inc];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (byte_q == LAST_BYTE) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + 5'd1;
            state_d = START;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 5'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 8'd0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (bus.trigger && busy_q && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      if (accept) snap_q <= {bus.total_cycles, bus.stall_cycles, bus.flush_cycles, bus.pc_in};
    end
  end

  assign bus.uart_tx    = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.drop_count = drop_q;

endmodule
